// File: rtl/qsn_left_len17.sv
// Left (inverse) cyclic shifter for 17-element vectors, 2-rank pipelined.
// Define QSN_LEFT_OUTREG_BYPASS_EN to drop rank B (1-cycle latency).
module qsn_left_len17 #(
  parameter int MSG_W = 1,
  parameter int SEL_W = 5
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               in_valid,
  input  logic [17*MSG_W-1:0] sw_in,
  input  logic [SEL_W-1:0]   sel,
  output logic [17*MSG_W-1:0] sw_out,
  output logic               out_valid,
  output logic               sel_err
);

  localparam int N  = 17;
  localparam int VW = N * MSG_W;

  typedef logic [VW-1:0] vec_t;

  function automatic vec_t rotl(input vec_t v, input int amt);
    vec_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*MSG_W +: MSG_W] = v[((i + amt) % N)*MSG_W +: MSG_W];
    end
    return r;
  endfunction

  logic in_err;
  vec_t s16;
  vec_t s8;
  vec_t a_in;

  assign in_err = (sel > SEL_W'(16));

  // Out-of-range slots carry zeros so the later stages need no extra gating.
  always_comb begin
    s16  = sel[4] ? rotl(sw_in, 16) : sw_in;
    s8   = sel[3] ? rotl(s16, 8) : s16;
    a_in = in_err ? '0 : s8;
  end

  vec_t       a_data;
  logic [2:0] a_sel;
  logic       a_valid;
  logic       a_err;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      a_data  <= '0;
      a_sel   <= '0;
      a_valid <= 1'b0;
      a_err   <= 1'b0;
    end else if (en) begin
      a_data  <= a_in;
      a_sel   <= sel[2:0];
      a_valid <= in_valid;
      a_err   <= in_valid & in_err;
    end
  end

  vec_t s4;
  vec_t s2;
  vec_t s1;

  always_comb begin
    s4 = a_sel[2] ? rotl(a_data, 4) : a_data;
    s2 = a_sel[1] ? rotl(s4, 2) : s4;
    s1 = a_sel[0] ? rotl(s2, 1) : s2;
  end

`ifdef QSN_LEFT_OUTREG_BYPASS_EN
  assign sw_out    = s1;
  assign out_valid = a_valid;
  assign sel_err   = a_err;
`else
  vec_t b_data;
  logic b_valid;
  logic b_err;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      b_data  <= '0;
      b_valid <= 1'b0;
      b_err   <= 1'b0;
    end else if (en) begin
      b_data  <= s1;
      b_valid <= a_valid;
      b_err   <= a_err;
    end
  end

  assign sw_out    = b_data;
  assign out_valid = b_valid;
  assign sel_err   = b_err;
`endif

endmodule

// File: doc/qsn_left_len17.md
Name: qsn_left_len17

Overview:
- Left-direction (inverse-rotation) cyclic shifter for 17-element message vectors.
- Undoes the circular rotation applied on the write path of the partial message-passing network, so messages return to their natural column order before VNU/CNU consumption.
- Pipelined log-shifter with 5 decomposed mux stages (shift weights 16, 8, 4, 2, 1).
- Adds a valid/enable pipeline and a shift-range check.

Parameters:
- MSG_W, 1: bit width of one vector element (message); element k occupies bits [k*MSG_W +: MSG_W].
- SEL_W, 5: shift-amount width; fixed at 5 for length 17 and must not be overridden.

Ports:
- sys_clk, input, 1: system clock; all state on rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- en, input, 1: pipeline advance enable; 0 freezes every pipeline register.
- in_valid, input, 1: sw_in/sel qualify this cycle.
- sw_in, input, 17*MSG_W: input vector, 17 elements.
- sel, input, 5: left-rotation amount, legal range 0..16.
- sw_out, output, 17*MSG_W: rotated vector.
- out_valid, output, 1: sw_out qualifies this cycle.
- sel_err, output, 1: the current output slot was issued with sel > 16.

Behaviour:
- Function: sw_out element i = sw_in element ((i + sel) mod 17), for i = 0..16; sel = 0 is pass-through.
- Reset (rstn low, asynchronous): all pipeline data registers 0, all valid bits 0, all staged sel bits 0. Outputs read sw_out = 0, out_valid = 0, sel_err = 0 immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.
- Pipeline, 2 register ranks:
  - Rank A, after the 16 and 8 mux stages: captures partial vector, sel[2:0], in_valid, and the error flag (sel > 16).
  - Rank B, after the 4/2/1 mux stages: feeds sw_out, out_valid, sel_err.
- Latency: 2 enabled cycles from in_valid sample to out_valid. Throughput 1 vector per enabled cycle.
- en = 0: ranks A and B hold all contents, including valid bits; inputs are ignored that cycle. en = 1: both ranks advance together.
- in_valid = 0 with en = 1: a bubble propagates (valid 0). Data registers still load but their contents are don't-care; the bench must not check sw_out while out_valid = 0.
- sel in 17..31: the data path produces all-zero output for that slot and sel_err = 1 alongside out_valid = 1. The error does not persist into later slots.
- Wrap-around: every mux stage rotates modulo 17. Stage 16 wraps by 16, stage 8 by 8, and so on. No bits are dropped at any stage for legal sel.
- Back-to-back vectors with different sel values never interfere, because each rank carries its own staged sel bits.
- Reset mid-stream: in-flight vectors are discarded and out_valid drops immediately. There is no recovery handshake; the upstream re-issues.

Optional Feature:
- Macro: QSN_LEFT_OUTREG_BYPASS_EN.
- Defined: rank B is removed and sw_out/out_valid/sel_err are combinational from rank A. Latency is 1 enabled cycle. en gates rank A only. Reset values are unchanged because they derive from rank A.
- Undefined (default): 2-cycle latency as above.

Test Plan:
- Reset while out_valid = 1 in flight: out_valid, sw_out and sel_err go to 0 before the next clock edge. First valid output appears 2 cycles after the first post-reset in_valid.
- MSG_W = 1, sw_in = 17'h00001, sel = 3, in_valid = 1, en = 1 -> 2 cycles later out_valid = 1, sw_out = 17'h04000 (bit 14 set, since 14 + 3 = 17 ≡ 0).
- MSG_W = 4, element k = k (k = 0..16), sel = 16 -> element i = (i + 16) mod 17: element 0 = 16, element 1 = 0, element 16 = 15.
- Streaming sel = 0, 1, 2, ..., 16 on consecutive cycles with a fixed vector -> 17 consecutive outputs, each matching the reference rotation, with no gaps.
- sel = 20 with in_valid = 1 -> out_valid = 1, sel_err = 1, sw_out = 0. The next vector with sel = 5 gives sel_err = 0 and a correct rotation.
- en held 0 for 3 cycles while two vectors are in flight -> outputs frozen. After en returns to 1, both emerge in order on consecutive cycles. With QSN_LEFT_OUTREG_BYPASS_EN defined, the same stimulus shows 1-cycle latency.
